// File: rtl/muldiv_unit_if.sv
// Handshake/data bundle between the EX stage and the RV32M multiply/divide unit.
//   start   : EX holds a valid M-extension instruction (held while stalled)
//   kill    : abort any in-flight operation, wins over start
//   op      : funct3 of the M instruction
//   rs1_val : operand A after forwarding
//   rs2_val : operand B after forwarding
//   busy    : stall request to the hazard unit
//   done    : one-cycle pulse, result valid
//   result  : operation result, held until the next done
// master = EX stage side, slave = muldiv_unit side.
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic            kill;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, kill, op, rs1_val, rs2_val,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, op, rs1_val, rs2_val,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Fixed latency: one IDLE accept cycle, XLEN CALC
// iterations (radix-2 shift-add multiply or restoring divide on magnitudes), one DONE cycle.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if slave modport (start/kill/op/rs1_val/rs2_val in,
//           busy/done/result out)
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);

   localparam int unsigned CntW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e          state_q, state_d;
   logic [2:0]      op_q;
   logic [XLEN-1:0] a_q, b_q;          // operand magnitudes, constant during CALC
   logic            neg_a_q, neg_b_q;
   logic            b_zero_q, ovf_q;
   logic [CntW-1:0] cnt_q;
   logic [2*XLEN-1:0] acc_q, acc_d;    // product, or remainder:quotient
   logic [XLEN-1:0] result_q, result_d;

   logic busy_c, done_c, accept, last;

   // Operand decode in IDLE
   logic            a_signed, b_signed, sign_a, sign_b;
   logic [XLEN-1:0] a_abs, b_abs;

   always_comb begin
      a_signed = bus.op[2] ? !bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
      b_signed = bus.op[2] ? !bus.op[0] : (bus.op[1:0] == 2'b01);
      sign_a   = a_signed & bus.rs1_val[XLEN-1];
      sign_b   = b_signed & bus.rs2_val[XLEN-1];
      a_abs    = sign_a ? -bus.rs1_val : bus.rs1_val;
      b_abs    = sign_b ? -bus.rs2_val : bus.rs2_val;
   end

   // One iteration of the datapath
   logic              mul_bit, div_bit, div_ok;
   logic [XLEN:0]     mul_sum, div_rem_sh;
   logic [XLEN-1:0]   div_diff;

   always_comb begin
      mul_bit    = b_q[cnt_q];
      mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mul_bit ? {1'b0, a_q} : '0);
      // Dividend bits enter MSB first
      div_bit    = a_q[CntW'(XLEN-1) - cnt_q];
      div_rem_sh = {acc_q[2*XLEN-1:XLEN], div_bit};
      div_ok     = (div_rem_sh >= {1'b0, b_q});
      // Only used when div_ok, where the true difference is below b_q and fits XLEN bits
      div_diff   = div_rem_sh[XLEN-1:0] - b_q;
      if (op_q[2]) begin
         acc_d = {(div_ok ? div_diff : div_rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};
      end else begin
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // Final sign correction and special-case overrides, evaluated on the last iteration
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, quo_s, rem_s, rs1_orig;

   always_comb begin
      prod     = (neg_a_q ^ neg_b_q) ? -acc_d : acc_d;
      quo      = acc_d[XLEN-1:0];
      rem      = acc_d[2*XLEN-1:XLEN];
      quo_s    = (neg_a_q ^ neg_b_q) ? -quo : quo;
      rem_s    = neg_a_q ? -rem : rem;
      rs1_orig = neg_a_q ? -a_q : a_q;
      result_d = prod[2*XLEN-1:XLEN];
      unique case (op_q)
         3'b000:  result_d = prod[XLEN-1:0];
         3'b100:  result_d = b_zero_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quo_s);
         3'b101:  result_d = b_zero_q ? '1 : quo;
         3'b110:  result_d = b_zero_q ? rs1_orig : (ovf_q ? '0 : rem_s);
         3'b111:  result_d = b_zero_q ? a_q : rem;
         default: result_d = prod[2*XLEN-1:XLEN];
      endcase
   end

   // FSM next state and outputs
   always_comb begin
      state_d = state_q;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      accept  = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               accept  = 1'b1;
               busy_c  = 1'b1;
               state_d = StCalc;
            end
         end
         StCalc: begin
            busy_c = 1'b1;
            if (cnt_q == CntW'(XLEN-1)) begin
               last    = 1'b1;
               state_d = StDone;
            end
         end
         // start still high here belongs to the finished instruction
         StDone: begin
            done_c  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (bus.kill) begin
         state_d = StIdle;
         busy_c  = 1'b0;
         done_c  = 1'b0;
         accept  = 1'b0;
         last    = 1'b0;
      end
   end

   assign bus.busy   = busy_c & rst_n;
   assign bus.done   = done_c;
   assign bus.result = result_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         b_zero_q <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_q     <= bus.op;
            a_q      <= a_abs;
            b_q      <= b_abs;
            neg_a_q  <= sign_a;
            neg_b_q  <= sign_b;
            b_zero_q <= (bus.rs2_val == '0);
            ovf_q    <= !bus.op[0] && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (bus.rs2_val == '1);
            cnt_q    <= '0;
            acc_q    <= '0;
         end else if (state_q == StCalc && !bus.kill) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
         end
         if (last) begin
            result_q <= result_d;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, kill/reset scenarios and
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model straight from the RV32M definitions
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int q;
      sa = $signed(a);
      sb = $signed(b);
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (o)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = $signed(a) / $signed(b);
            return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            q = $signed(a) % $signed(b);
            return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Called just after a negedge; drives the op, leaves start high and returns in the DONE
   // cycle. Operand inputs are scrambled during CALC to show they are only sampled in IDLE.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
      logic [31:0] exp;
      int lat, busy_cnt;
      bit got;
      bus.start   = 1'b1;
      bus.op      = o;
      bus.rs1_val = a;
      bus.rs2_val = b;
      exp = ref_model(o, a, b);
      lat = 0;
      busy_cnt = 0;
      got = 1'b0;
      #1;
      for (int k = 0; k < 60; k++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         if (bus.busy) busy_cnt++;
         lat++;
         @(negedge clk);
         bus.rs1_val = $urandom;
         bus.rs2_val = $urandom;
         #1;
      end
      check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
      check_eq({tag, "_latency"}, 64'(lat), 64'd33);
      check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      check_eq({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
      check_eq({tag, "_result"}, 64'(bus.result), 64'(exp));
   endtask

   // Instruction leaves EX: drop start and confirm no restart and a single-cycle done
   task automatic end_op(input string tag);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check_eq({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      check_eq({tag, "_idle_done"}, 64'(bus.done), 64'd0);
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t dir[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      int mode;
      logic [2:0] ro;
      logic [31:0] ra, rb;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b1;
      bus.start = 1'b0;
      bus.kill = 1'b0;
      bus.op = '0;
      bus.rs1_val = '0;
      bus.rs2_val = '0;
      #1 rst_n = 1'b0;
      bus.start = 1'b1;
      #2;
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_done", 64'(bus.done), 64'd0);
      check_eq("rst_result", 64'(bus.result), 64'd0);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_busy", 64'(bus.busy), 64'd0);

      dir.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD});
      dir.push_back('{3'd1, 32'h8000_0000, 32'hFFFF_FFFF});
      dir.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF});
      dir.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF});
      dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002});
      dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002});
      dir.push_back('{3'd5, 32'd100, 32'd7});
      dir.push_back('{3'd7, 32'd100, 32'd7});
      dir.push_back('{3'd4, 32'h0000_1234, 32'h0});
      dir.push_back('{3'd5, 32'h0000_1234, 32'h0});
      dir.push_back('{3'd6, 32'h0000_1234, 32'h0});
      dir.push_back('{3'd7, 32'h0000_1234, 32'h0});
      dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF});
      dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF});
      dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0});

      foreach (dir[i]) begin
         @(negedge clk);
         do_op(dir[i].o, dir[i].a, dir[i].b, $sformatf("dir%0d", i));
         end_op($sformatf("dir%0d", i));
      end

      // Back-to-back: MUL then DIVU with start held through DONE
      @(negedge clk);
      do_op(3'd0, 32'd12345, 32'd678, "b2b_mul");
      @(negedge clk);
      do_op(3'd5, 32'd1000000, 32'd37, "b2b_divu");
      end_op("b2b");

      // Kill at CALC iteration 10
      held = bus.result;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 3'd0;
      bus.rs1_val = 32'hDEAD_BEEF;
      bus.rs2_val = 32'h0000_0003;
      repeat (11) @(negedge clk);
      bus.kill = 1'b1;
      #1;
      check_eq("kill_busy", 64'(bus.busy), 64'd0);
      check_eq("kill_done", 64'(bus.done), 64'd0);
      check_eq("kill_result", 64'(bus.result), 64'(held));
      @(negedge clk);
      bus.kill = 1'b0;
      check_eq("kill_result_after", 64'(bus.result), 64'(held));
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "after_kill");
      end_op("after_kill");

      // Kill and start together in IDLE
      @(negedge clk);
      bus.start = 1'b1;
      bus.kill = 1'b1;
      #1;
      check_eq("kill_start_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.kill = 1'b0;
      #1;
      check_eq("kill_start_no_run", 64'(bus.busy), 64'd0);

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 3'd5;
      bus.rs1_val = 32'd999;
      bus.rs2_val = 32'd10;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
      check_eq("mid_rst_done", 64'(bus.done), 64'd0);
      check_eq("mid_rst_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      rst_n = 1'b1;
      #1;
      check_eq("mid_rst_idle", 64'(bus.busy), 64'd0);

      // Randomized operations, sometimes back-to-back
      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 7);
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         if (mode == 0) rb = 32'h0;
         else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         else if (mode == 2) begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
         else if (mode == 3) rb = {{16{rb[15]}}, rb[15:0]};
         @(negedge clk);
         do_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
         if ($urandom_range(0, 1) == 0) end_op($sformatf("rnd%0d", i));
      end
      end_op("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
